// File: rtl/mem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// mem_fetch_ctrl
//
// Fetch and memory-access sequencer for the multi-cycle CPU. It owns the PC
// and the instruction register. It places instruction fetches, data loads,
// data stores and branch redirects onto one single-port RAM interface. The
// RAM may insert any number of wait states through mem_ready. The execution
// controller hands over one op at a time through op_valid/op_ready. A
// watchdog moves the block into a sticky error state when the memory stops
// responding.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   mem_cmd    memory command (00 none, 01 read, 10 write)
//   mem_addr   memory address
//   mem_wdata  store data, held after the store completes
//   mem_rdata  read data, valid with mem_ready
//   mem_ready  access completes when mem_cmd != none and mem_ready = 1
//   op_valid   execution controller presents an op
//   op_kind    00 NEXT, 01 LOAD, 10 STORE, 11 BRANCH
//   op_addr    data address (LOAD/STORE) or absolute branch target
//   op_wdata   store data for STORE
//   op_ready   block accepts an op this cycle (DISPATCH only)
//   ir         instruction register
//   ir_valid   one-cycle pulse: ir was just loaded
//   ld_data    result of the last load
//   ld_valid   one-cycle pulse: ld_data was just updated
//   pc         address of the next instruction to fetch
//   bus_err    sticky watchdog error
// -----------------------------------------------------------------------------
module mem_fetch_ctrl #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              op_valid,
  input  logic [1:0]        op_kind,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_wdata,
  output logic              op_ready,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              bus_err
);

  // The watchdog counter only has to reach TIMEOUT, so it is sized for that.
  // It keeps a 1-bit minimum so the design stays legal with the watchdog off.
  localparam int WC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WC_W-1:0]   WC_LIMIT = (TIMEOUT > 0) ? WC_W'(TIMEOUT - 1) : '0;
  localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(RESET_PC);

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [1:0] OP_NEXT   = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_STORE  = 2'b10;
  localparam logic [1:0] OP_BRANCH = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DISPATCH = 3'd1,
    S_DATA_RD  = 3'd2,
    S_DATA_WR  = 3'd3,
    S_ERR      = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W-1:0] ir_reg;
  logic [DATA_W-1:0] ld_data_reg;
  logic [ADDR_W-1:0] data_addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [WC_W-1:0]   wait_cnt_reg;
  logic              ir_valid_reg;
  logic              ld_valid_reg;
  logic              in_access;
  logic              wd_expired;

  assign in_access = (state_reg == S_FETCH) || (state_reg == S_DATA_RD) ||
                     (state_reg == S_DATA_WR);

  // Exactly TIMEOUT consecutive not-ready cycles trip the error. A ready on
  // the last allowed cycle still completes, because ready is checked first.
  assign wd_expired = (TIMEOUT != 0) && (wait_cnt_reg == WC_LIMIT);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_FETCH, S_DATA_RD, S_DATA_WR: begin
        if (mem_ready) begin
          state_next = S_DISPATCH;
        end else if (wd_expired) begin
          state_next = S_ERR;
        end
      end
      S_DISPATCH: begin
        if (op_valid) begin
          unique case (op_kind)
            OP_LOAD:  state_next = S_DATA_RD;
            OP_STORE: state_next = S_DATA_WR;
            default:  state_next = S_FETCH;   // NEXT and BRANCH both refetch
          endcase
        end
      end
      S_ERR:   state_next = S_ERR;
      default: state_next = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_cmd  = MNONE;
    mem_addr = pc_reg;
    op_ready = 1'b0;
    bus_err  = 1'b0;
    unique case (state_reg)
      S_FETCH: begin
        mem_cmd  = MREAD;
        mem_addr = pc_reg;
      end
      S_DATA_RD: begin
        mem_cmd  = MREAD;
        mem_addr = data_addr_reg;
      end
      S_DATA_WR: begin
        mem_cmd  = MWRITE;
        mem_addr = data_addr_reg;
      end
      S_DISPATCH: op_ready = 1'b1;
      S_ERR:      bus_err  = 1'b1;
      default: ;
    endcase
    // An access abandoned by reset must not stay on the bus while reset
    // is held. The reset values already select FETCH, so the command is
    // masked here until reset is released.
    if (reset) begin
      mem_cmd = MNONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: PC, IR, load data, store buffer, watchdog, result pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg        <= PC_INIT;
      ir_reg        <= '0;
      ld_data_reg   <= '0;
      data_addr_reg <= '0;
      wdata_reg     <= '0;
      wait_cnt_reg  <= '0;
      ir_valid_reg  <= 1'b0;
      ld_valid_reg  <= 1'b0;
    end else begin
      ir_valid_reg <= 1'b0;
      ld_valid_reg <= 1'b0;

      if (in_access) begin
        if (mem_ready) begin
          wait_cnt_reg <= '0;
        end else begin
          wait_cnt_reg <= wait_cnt_reg + WC_W'(1);
        end
      end

      unique case (state_reg)
        S_FETCH: begin
          if (mem_ready) begin
            ir_reg       <= mem_rdata;
            ir_valid_reg <= 1'b1;
            pc_reg       <= pc_reg + ADDR_W'(1);   // wraps at all-ones
          end
        end
        S_DATA_RD: begin
          if (mem_ready) begin
            ld_data_reg  <= mem_rdata;
            ld_valid_reg <= 1'b1;
          end
        end
        S_DISPATCH: begin
          // Clearing here means every access state is entered with a fresh count.
          wait_cnt_reg <= '0;
          if (op_valid) begin
            unique case (op_kind)
              OP_LOAD: data_addr_reg <= op_addr;
              OP_STORE: begin
                data_addr_reg <= op_addr;
                wdata_reg     <= op_wdata;
              end
              OP_BRANCH: pc_reg <= op_addr;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign pc        = pc_reg;
  assign ir        = ir_reg;
  assign ir_valid  = ir_valid_reg;
  assign ld_data   = ld_data_reg;
  assign ld_valid  = ld_valid_reg;
  assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for mem_fetch_ctrl (TIMEOUT = 4). A behavioural RAM inserts a
// programmable number of wait states. Ops are applied from a table of
// hand-computed records. Reset, idle, watchdog and reset-mid-access cases
// are written out as separate sequences.
// -----------------------------------------------------------------------------
module tb_mem_fetch_ctrl;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              op_valid;
  logic [1:0]        op_kind;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              op_ready;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_valid;
  logic [ADDR_W-1:0] pc;
  logic              bus_err;

  mem_fetch_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RESET_PC(0),
    .TIMEOUT (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_cmd  (mem_cmd),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .op_valid (op_valid),
    .op_kind  (op_kind),
    .op_addr  (op_addr),
    .op_wdata (op_wdata),
    .op_ready (op_ready),
    .ir       (ir),
    .ir_valid (ir_valid),
    .ld_data  (ld_data),
    .ld_valid (ld_valid),
    .pc       (pc),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // RAM model: ready after wait_n not-ready cycles of the current access
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic ram_loaded = 1'b0;
  int   acc_cnt = 0;
  int   wait_n  = 0;

  assign mem_ready = (acc_cnt >= wait_n);
  assign mem_rdata = ram[mem_addr];

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= 16'h1000 + 16'(i);
      ram[9'h000] <= 16'hD105;
      ram[9'h040] <= 16'hBEEF;
      ram[9'h1FF] <= 16'hA5A5;
      ram_loaded  <= 1'b1;
    end else if (mem_cmd == 2'b10 && mem_ready) begin
      ram[mem_addr] <= mem_wdata;
    end
    if (mem_cmd != 2'b00 && !mem_ready) acc_cnt <= acc_cnt + 1;
    else                                acc_cnt <= 0;
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  kind;
    logic [8:0]  addr;
    logic [15:0] wdata;
    int          waits;
    logic [1:0]  exp_cmd;
    logic [8:0]  exp_addr;
    int          exp_ncyc;
    int          exp_irv;
    int          exp_ldv;
    int          exp_lat;
    logic [8:0]  exp_pc;
    logic [15:0] exp_ir;
    logic [15:0] exp_ld;
  } vec_t;

  // Results of one run_op
  int          r_ncyc, r_irv, r_ldv, r_lat;
  logic [1:0]  r_cmd;
  logic [8:0]  r_addr;
  logic [15:0] r_wdata;
  bit          r_stable, r_done;

  // Called at a negedge with the DUT in DISPATCH. Presents one op, then
  // drives a junk BRANCH while the DUT is busy (that op must be ignored).
  // Returns when op_ready is seen again.
  task automatic run_op(input logic [1:0] kind, input logic [8:0] addr,
                        input logic [15:0] wdata, input int waits);
    wait_n   = waits;
    op_valid = 1'b1;
    op_kind  = kind;
    op_addr  = addr;
    op_wdata = wdata;
    r_ncyc = 0; r_irv = 0; r_ldv = 0; r_lat = 0;
    r_cmd = 2'b00; r_addr = '0; r_wdata = '0;
    r_stable = 1'b1; r_done = 1'b0;
    for (int k = 1; k <= 40 && !r_done; k++) begin
      @(negedge clk);
      if (mem_cmd != 2'b00) begin
        if (r_ncyc == 0) begin
          r_cmd = mem_cmd; r_addr = mem_addr; r_wdata = mem_wdata;
        end else if (mem_cmd != r_cmd || mem_addr != r_addr) begin
          r_stable = 1'b0;
        end
        r_ncyc++;
      end
      if (ir_valid) begin r_irv++; if (r_lat == 0) r_lat = k; end
      if (ld_valid) begin r_ldv++; if (r_lat == 0) r_lat = k; end
      if (op_ready) begin
        r_done   = 1'b1;
        op_valid = 1'b0;
      end else begin
        op_valid = 1'b1;
        op_kind  = 2'b11;
        op_addr  = 9'h0AA;
      end
    end
  endtask

  vec_t vecs [9];
  int   cnt;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // kind addr wdata waits | cmd addr ncyc irv ldv lat pc ir ld
    vecs[0] = '{2'b01, 9'h040, 16'h0000, 2, 2'b01, 9'h040, 3, 0, 1, 4, 9'h001, 16'hD105, 16'hBEEF};
    vecs[1] = '{2'b10, 9'h041, 16'h1234, 0, 2'b10, 9'h041, 1, 0, 0, 0, 9'h001, 16'hD105, 16'hBEEF};
    vecs[2] = '{2'b01, 9'h041, 16'h0000, 0, 2'b01, 9'h041, 1, 0, 1, 2, 9'h001, 16'hD105, 16'h1234};
    vecs[3] = '{2'b00, 9'h000, 16'h0000, 1, 2'b01, 9'h001, 2, 1, 0, 3, 9'h002, 16'h1001, 16'h1234};
    vecs[4] = '{2'b11, 9'h1FF, 16'h0000, 0, 2'b01, 9'h1FF, 1, 1, 0, 2, 9'h000, 16'hA5A5, 16'h1234};
    vecs[5] = '{2'b00, 9'h000, 16'h0000, 0, 2'b01, 9'h000, 1, 1, 0, 2, 9'h001, 16'hD105, 16'h1234};
    vecs[6] = '{2'b10, 9'h000, 16'hCAFE, 3, 2'b10, 9'h000, 4, 0, 0, 0, 9'h001, 16'hD105, 16'h1234};
    vecs[7] = '{2'b00, 9'h000, 16'h0000, 3, 2'b01, 9'h001, 4, 1, 0, 5, 9'h002, 16'h1001, 16'h1234};
    vecs[8] = '{2'b01, 9'h000, 16'h0000, 0, 2'b01, 9'h000, 1, 0, 1, 2, 9'h002, 16'h1001, 16'hCAFE};

    reset = 1'b1; op_valid = 1'b0; op_kind = 2'b00; op_addr = '0; op_wdata = '0;
    wait_n = 0;

    // ---- reset state and first fetch -------------------------------------
    repeat (3) @(negedge clk);
    chk("rst_cmd", 0, 32'(mem_cmd), 0);
    chk("rst_op_ready", 0, 32'(op_ready), 0);
    chk("rst_bus_err", 0, 32'(bus_err), 0);
    chk("rst_pc", 0, 32'(pc), 0);
    chk("rst_ir", 0, 32'(ir), 0);
    chk("rst_irv", 0, 32'(ir_valid), 0);
    chk("rst_ldv", 0, 32'(ld_valid), 0);
    reset = 1'b0;
    #1;
    chk("boot_cmd", 0, 32'(mem_cmd), 32'h1);
    chk("boot_addr", 0, 32'(mem_addr), 0);
    @(negedge clk);
    chk("boot_ir", 0, 32'(ir), 32'hD105);
    chk("boot_irv", 0, 32'(ir_valid), 1);
    chk("boot_pc", 0, 32'(pc), 1);
    chk("boot_op_ready", 0, 32'(op_ready), 1);

    // ---- table-driven ops ------------------------------------------------
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].kind, vecs[i].addr, vecs[i].wdata, vecs[i].waits);
      $display("op %0d kind=%0d addr=%h waits=%0d -> ncyc=%0d irv=%0d ldv=%0d lat=%0d pc=%h ir=%h ld=%h",
               i, vecs[i].kind, vecs[i].addr, vecs[i].waits, r_ncyc, r_irv, r_ldv, r_lat,
               pc, ir, ld_data);
      chk("done", i, 32'(r_done), 1);
      chk("cmd", i, 32'(r_cmd), 32'(vecs[i].exp_cmd));
      chk("addr", i, 32'(r_addr), 32'(vecs[i].exp_addr));
      chk("stable", i, 32'(r_stable), 1);
      chk("ncyc", i, 32'(r_ncyc), 32'(vecs[i].exp_ncyc));
      chk("irv_cnt", i, 32'(r_irv), 32'(vecs[i].exp_irv));
      chk("ldv_cnt", i, 32'(r_ldv), 32'(vecs[i].exp_ldv));
      chk("latency", i, 32'(r_lat), 32'(vecs[i].exp_lat));
      chk("pc", i, 32'(pc), 32'(vecs[i].exp_pc));
      chk("ir", i, 32'(ir), 32'(vecs[i].exp_ir));
      chk("ld_data", i, 32'(ld_data), 32'(vecs[i].exp_ld));
      chk("bus_err", i, 32'(bus_err), 0);
      if (vecs[i].kind == 2'b10) chk("wdata", i, 32'(r_wdata), 32'(vecs[i].wdata));
    end
    chk("ram41", 0, 32'(ram[9'h041]), 32'h1234);
    chk("wdata_hold", 0, 32'(mem_wdata), 32'hCAFE);

    // ---- idle in DISPATCH ------------------------------------------------
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_op_ready", k, 32'(op_ready), 1);
      chk("idle_cmd", k, 32'(mem_cmd), 0);
    end

    // ---- watchdog: memory never ready during FETCH -----------------------
    wait_n = 100;
    op_valid = 1'b1; op_kind = 2'b00;
    @(negedge clk);
    op_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (mem_cmd == 2'b01) cnt++;
      @(negedge clk);
    end
    $display("watchdog: mread_cycles=%0d bus_err=%0d", cnt, bus_err);
    chk("wd_mread_cycles", 0, 32'(cnt), 4);
    chk("wd_bus_err", 0, 32'(bus_err), 1);
    chk("wd_cmd", 0, 32'(mem_cmd), 0);
    chk("wd_op_ready", 0, 32'(op_ready), 0);
    // ERR must ignore a now-ready memory and a presented op
    wait_n = 0;
    op_valid = 1'b1; op_kind = 2'b11; op_addr = 9'h055;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ir_valid || op_ready || mem_cmd != 2'b00 || !bus_err) cnt++;
    end
    op_valid = 1'b0;
    chk("err_sticky", 0, 32'(cnt), 0);
    chk("err_pc", 0, 32'(pc), 2);

    // ---- reset clears ERR, refetch from RESET_PC -------------------------
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_bus_err", 0, 32'(bus_err), 0);
    chk("rst2_cmd", 0, 32'(mem_cmd), 0);
    reset = 1'b0;
    #1;
    chk("boot2_cmd", 0, 32'(mem_cmd), 32'h1);
    chk("boot2_addr", 0, 32'(mem_addr), 0);
    @(negedge clk);
    chk("boot2_ir", 0, 32'(ir), 32'hCAFE);
    chk("boot2_irv", 0, 32'(ir_valid), 1);

    // ---- reset during the second wait cycle of DATA_RD -------------------
    wait_n = 100;
    op_valid = 1'b1; op_kind = 2'b01; op_addr = 9'h040;
    @(negedge clk);                         // first wait cycle
    op_valid = 1'b0;
    @(negedge clk);                         // second wait cycle
    chk("mid_cmd", 0, 32'(mem_cmd), 32'h1);
    chk("mid_addr", 0, 32'(mem_addr), 32'h40);
    reset = 1'b1;
    wait_n = 0;                             // memory would answer if still asked
    @(negedge clk);
    chk("mid_rst_cmd", 0, 32'(mem_cmd), 0);
    chk("mid_rst_ldv", 0, 32'(ld_valid), 0);
    @(negedge clk);
    chk("mid_rst_ldv", 1, 32'(ld_valid), 0);
    chk("mid_rst_ld", 0, 32'(ld_data), 0);
    reset = 1'b0;
    #1;
    chk("mid_boot_cmd", 0, 32'(mem_cmd), 32'h1);
    chk("mid_boot_addr", 0, 32'(mem_addr), 0);
    @(negedge clk);
    chk("mid_boot_irv", 0, 32'(ir_valid), 1);
    chk("mid_boot_ldv", 0, 32'(ld_valid), 0);
    chk("mid_boot_pc", 0, 32'(pc), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_fetch_ctrl.md
Name: mem_fetch_ctrl

Overview:
Parametrised fetch and memory-access sequencer for the multi-cycle CPU. It owns the PC and instruction register. It arbitrates instruction fetch, data load/store and branch redirect onto the single-port RAM interface, and supports variable-latency memory through a ready handshake. The execution state controller drives it through a one-deep op handshake. A watchdog flags a memory that never responds.

Parameters:
ADDR_W, 9, width of the PC and memory address.
DATA_W, 16, width of instruction and data words.
RESET_PC, 0, PC value loaded on reset.
TIMEOUT, 15, maximum wait cycles per access before a bus error; 0 disables the watchdog.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
mem_cmd  out  2  memory command: 00 MNONE, 01 MREAD, 10 MWRITE.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  store data.
mem_rdata  in  DATA_W  read data, valid when mem_ready=1.
mem_ready  in  1  access completes on a cycle where mem_cmd!=MNONE and mem_ready=1.
op_valid  in  1  execution controller presents an op.
op_kind  in  2  00 NEXT, 01 LOAD, 10 STORE, 11 BRANCH.
op_addr  in  ADDR_W  data address (LOAD/STORE) or absolute branch target (BRANCH).
op_wdata  in  DATA_W  store data (STORE).
op_ready  out  1  block accepts an op this cycle.
ir  out  DATA_W  instruction register.
ir_valid  out  1  one-cycle pulse, new ir loaded.
ld_data  out  DATA_W  last load result.
ld_valid  out  1  one-cycle pulse, ld_data updated.
pc  out  ADDR_W  address of the next instruction to fetch.
bus_err  out  1  sticky watchdog error.

Behaviour:
- Reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values: state=FETCH, pc=RESET_PC, ir=0, ld_data=0, data_addr=0, mem_wdata=0, wait_cnt=0. Pulses ir_valid and ld_valid are 0, op_ready=0, bus_err=0.
- First cycle after reset deasserts: mem_cmd=MREAD, mem_addr=RESET_PC.
- States: FETCH, DISPATCH, DATA_RD, DATA_WR, ERR.
- mem_cmd and mem_addr are combinational from state:
  - FETCH: MREAD, pc.
  - DATA_RD: MREAD, data_addr.
  - DATA_WR: MWRITE, data_addr.
  - DISPATCH and ERR: MNONE, pc.
- Accesses may complete in the same cycle they are issued (zero-wait). The address and command hold stable until completion.
- FETCH with mem_ready=1: ir<=mem_rdata, ir_valid=1 next cycle, pc<=pc+1 (mod 2^ADDR_W, so all-ones wraps to 0), then DISPATCH.
- DISPATCH: op_ready=1. With op_valid=0 the block stays in DISPATCH. An op is accepted on op_valid&op_ready:
  - NEXT -> FETCH.
  - LOAD: data_addr<=op_addr -> DATA_RD.
  - STORE: data_addr<=op_addr, mem_wdata<=op_wdata -> DATA_WR.
  - BRANCH: pc<=op_addr -> FETCH.
- DATA_RD with mem_ready=1: ld_data<=mem_rdata, ld_valid pulses next cycle -> DISPATCH.
- DATA_WR with mem_ready=1 -> DISPATCH. mem_wdata holds its value after the store.
- op_valid is ignored outside DISPATCH; the op is neither latched nor queued.
- ir, ld_data and pc change only as stated above.
- Latency, zero-wait memory: fetch to ir_valid is 2 cycles from entry to FETCH; LOAD accept to ld_valid is 2 cycles.
- Each wait state adds 1 cycle.
- Watchdog:
  - wait_cnt clears on entry to every access state and on completion.
  - wait_cnt increments each cycle in FETCH, DATA_RD or DATA_WR with mem_ready=0.
  - If TIMEOUT!=0 and wait_cnt==TIMEOUT-1 with mem_ready=0, next state is ERR. Exactly TIMEOUT consecutive not-ready cycles trip the error; mem_ready=1 on that cycle still completes normally.
  - wait_cnt width is clog2(TIMEOUT+1), minimum 1.
- ERR: mem_cmd=MNONE, op_ready=0, bus_err=1. The block stays in ERR until reset.
- Reset mid-access abandons the access. mem_cmd=MNONE from the cycle after the reset edge until reset deasserts, then the block fetches from RESET_PC. No ir_valid or ld_valid is produced for the abandoned access.
- mem_ready while in DISPATCH or ERR is ignored.

Test Plan:
- Reset, zero-wait memory, RAM[0]=16'hD105: mem_cmd=01, addr=0 on cycle 1; ir=16'hD105, ir_valid pulse, pc=1 on cycle 2; op_ready=1.
- From DISPATCH, LOAD op_addr=9'h040, RAM[0x40]=16'hBEEF, 2 wait states: mem_cmd=01, addr=0x40 held 3 cycles; ld_data=16'hBEEF, ld_valid one pulse; pc unchanged.
- STORE op_addr=9'h041, op_wdata=16'h1234, zero-wait: exactly one cycle of mem_cmd=10, addr=0x41, wdata=16'h1234; RAM[0x41]=16'h1234; return to DISPATCH.
- BRANCH op_addr=9'h1FF, then NEXT after the fetch: fetch at 0x1FF, pc wraps to 0, the following fetch is at address 0.
- TIMEOUT=4, mem_ready held 0 during FETCH: 4 MREAD cycles, then ERR with bus_err=1, mem_cmd=00, op_ready=0 until reset. Repeat with mem_ready=1 on the 4th cycle: completes, no error.
- Reset asserted during the second wait cycle of DATA_RD: mem_cmd=00 after the edge, no ld_valid; after release, MREAD at RESET_PC.
